// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
//
// 8N1 UART receiver (LSB first, idle-high line). The raw line is passed
// through a two-flop synchronizer, and the FSM watches only the synchronized
// copy. An internal baud counter times each bit and samples it in the middle
// of the bit period. Each correctly framed byte is presented on rx_data with a
// one-cycle rx_valid strobe. A bad stop bit produces one frame_error strobe.
// Byte and newline counters track the transmitter's data/line counters, so a
// loopback checker can compare the two sides directly.
//
// Optional feature macro: RX_FRAME_ERR_COUNT_EN
//   When defined, this adds the frame_err_count output. It is a saturating
//   count of frame_error strobes, and both rst and clear_counters zero it.
//
// Ports
//   system_clock    in   1   single clock for all logic
//   rst             in   1   synchronous, active-high reset
//   rx              in   1   asynchronous serial input, idle high
//   clear_counters  in   1   synchronous clear of the counters
//   rx_data         out  8   last correctly framed byte
//   rx_valid        out  1   one-cycle strobe when rx_data updates
//   frame_error     out  1   one-cycle strobe on a bad stop bit
//   busy            out  1   FSM is not in IDLE
//   byte_counter    out  17  good bytes received (wraps)
//   line_counter    out  8   good bytes equal to NEWLINE_CHAR (wraps)
//   frame_err_count out  8   saturating frame error count (macro only)
//
// State table
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge on rxs
//   START     | timing half a bit to re-check the start bit (glitch filter)
//   DATA      | sampling the 8 data bits at mid-bit, LSB first
//   STOP      | sampling the stop bit; this decides good frame or error
//   WAIT_IDLE | after a framing error, waiting for the line to return high
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  NEWLINE_CHAR = 8'h0A
) (
  input  logic        system_clock,
  input  logic        rst,
  input  logic        rx,
  input  logic        clear_counters,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_error,
  output logic        busy,
  output logic [16:0] byte_counter,
  output logic [7:0]  line_counter
`ifdef RX_FRAME_ERR_COUNT_EN
  ,
  output logic [7:0]  frame_err_count
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // START waits half a bit so that every later sample lands at mid-bit.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              rx_meta_q, rx_meta_d;
  logic              rxs_q, rxs_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_error_q, frame_error_d;
  logic              busy_q, busy_d;
  logic [16:0]       byte_counter_q, byte_counter_d;
  logic [7:0]        line_counter_q, line_counter_d;
  logic              good_frame;
  logic              bad_frame;

  // Two-flop synchronizer for the asynchronous line.
  always_comb begin
    rx_meta_d = rx;
    rxs_d     = rx_meta_q;
  end

  // Next-state logic and registered outputs.
  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;
    good_frame    = 1'b0;
    bad_frame     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          baud_d  = '0;
        end
      end

      START: begin
        if (baud_q == HALF_LAST) begin
          if (!rxs_q) begin
            state_d   = DATA;
            baud_d    = '0;
            bit_idx_d = 3'd0;
          end else begin
            // The line went high before mid-bit. Treat it as a glitch.
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d             = '0;
          shift_d[bit_idx_q] = rxs_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (rxs_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            good_frame = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_error_d = 1'b1;
            bad_frame     = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      WAIT_IDLE: begin
        // A held-low line or a break stays here, so it gives only one error.
        if (rxs_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // clear_counters takes priority over an increment in the same cycle.
    byte_counter_d = byte_counter_q;
    line_counter_d = line_counter_q;
    if (clear_counters) begin
      byte_counter_d = '0;
      line_counter_d = '0;
    end else if (good_frame) begin
      byte_counter_d = byte_counter_q + 17'd1;
      if (shift_q == NEWLINE_CHAR) begin
        line_counter_d = line_counter_q + 8'd1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge system_clock) begin
    if (rst) begin
      state_q        <= IDLE;
      baud_q         <= '0;
      bit_idx_q      <= 3'd0;
      shift_q        <= 8'h00;
      rx_meta_q      <= 1'b1;
      rxs_q          <= 1'b1;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      frame_error_q  <= 1'b0;
      busy_q         <= 1'b0;
      byte_counter_q <= '0;
      line_counter_q <= '0;
    end else begin
      state_q        <= state_d;
      baud_q         <= baud_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rx_meta_q      <= rx_meta_d;
      rxs_q          <= rxs_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_error_q  <= frame_error_d;
      busy_q         <= busy_d;
      byte_counter_q <= byte_counter_d;
      line_counter_q <= line_counter_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign frame_error  = frame_error_q;
  assign busy         = busy_q;
  assign byte_counter = byte_counter_q;
  assign line_counter = line_counter_q;

`ifdef RX_FRAME_ERR_COUNT_EN
  logic [7:0] frame_err_count_q, frame_err_count_d;

  // Saturating count: holds at 0xFF instead of wrapping.
  always_comb begin
    frame_err_count_d = frame_err_count_q;
    if (clear_counters) begin
      frame_err_count_d = 8'h00;
    end else if (bad_frame && (frame_err_count_q != 8'hFF)) begin
      frame_err_count_d = frame_err_count_q + 8'd1;
    end
  end

  always_ff @(posedge system_clock) begin
    if (rst) begin
      frame_err_count_q <= 8'h00;
    end else begin
      frame_err_count_q <= frame_err_count_d;
    end
  end

  assign frame_err_count = frame_err_count_q;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
module tb_uart_rx_fsm;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        clear_counters;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_error;
  logic        busy;
  logic [16:0] byte_counter;
  logic [7:0]  line_counter;
`ifdef RX_FRAME_ERR_COUNT_EN
  logic [7:0]  frame_err_count;
`endif

  uart_rx_fsm #(.CLKS_PER_BIT(CPB), .NEWLINE_CHAR(8'h0A)) dut (
    .system_clock   (clk),
    .rst            (rst),
    .rx             (rx),
    .clear_counters (clear_counters),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .frame_error    (frame_error),
    .busy           (busy),
    .byte_counter   (byte_counter),
    .line_counter   (line_counter)
`ifdef RX_FRAME_ERR_COUNT_EN
    ,
    .frame_err_count(frame_err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    logic [16:0] bc;
    logic [7:0]  lc;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int events   = 0;

  logic [16:0] m_bytes;
  logic [7:0]  m_lines;
  logic [7:0]  m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected event for every strobe the DUT presents.
  always @(negedge clk) begin
    if (rx_valid || frame_error) begin
      events++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event valid=%0b ferr=%0b data=0x%0h", rx_valid, frame_error, rx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_valid", {31'd0, rx_valid}, {31'd0, !e.is_err});
        check("event_ferr", {31'd0, frame_error}, {31'd0, e.is_err});
        check("event_data", {24'd0, rx_data}, {24'd0, e.data});
        check("event_bytes", {15'd0, byte_counter}, {15'd0, e.bc});
        check("event_lines", {24'd0, line_counter}, {24'd0, e.lc});
      end
    end
  end

  // Hand-computed expectation for a good frame; the counters mirror the design.
  task automatic expect_good(input logic [7:0] d);
    exp_t e;
    m_bytes = m_bytes + 17'd1;
    if (d == 8'h0A) m_lines = m_lines + 8'd1;
    m_data = d;
    e.is_err = 1'b0; e.data = d; e.bc = m_bytes; e.lc = m_lines;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1; e.data = m_data; e.bc = m_bytes; e.lc = m_lines;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge n clocks later.
  task automatic send_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
    send_bit(1'b1, CPB);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] d,
                                    input logic [16:0] bc, input logic [7:0] lc);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_data"}, {24'd0, rx_data}, {24'd0, d});
    check({tag, "_bytes"}, {15'd0, byte_counter}, {15'd0, bc});
    check({tag, "_lines"}, {24'd0, line_counter}, {24'd0, lc});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx = 1'b1; clear_counters = 1'b0;
    m_bytes = '0; m_lines = '0; m_data = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_error}, 32'd0);
    check_idle_outputs("rst", 8'h00, 17'd0, 8'd0);
    rst = 1'b0;
    send_bit(1'b1, CPB);

    // Glitch: four clocks low, far short of the half-bit start check.
    send_bit(1'b0, 4);
    send_bit(1'b1, 2 * CPB);
    check_idle_outputs("glitch", 8'h00, 17'd0, 8'd0);

    // Single byte.
    expect_good(8'h55);
    send_frame(8'h55);
    check_idle_outputs("single", 8'h55, 17'd1, 8'd0);

    // Newline counting: counters cleared while idle, then two frames back to back.
    clear_counters = 1'b1;
    @(negedge clk);
    clear_counters = 1'b0;
    m_bytes = '0; m_lines = '0;
    check("clear_idle_bytes", {15'd0, byte_counter}, 32'd0);
    expect_good(8'h0A);
    expect_good(8'h41);
    send_frame(8'h0A);
    send_frame(8'h41);
    send_bit(1'b1, 4);
    check_idle_outputs("newline", 8'h41, 17'd2, 8'd1);

    // Framing error: 0xFF data, then the line is held low for three bit times.
    expect_err();
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(1'b1, CPB);
    send_bit(1'b0, 3 * CPB);
    check("ferr_busy_held", {31'd0, busy}, 32'd1);
    send_bit(1'b1, CPB);
    check_idle_outputs("ferr", 8'h41, 17'd2, 8'd1);
`ifdef RX_FRAME_ERR_COUNT_EN
    check("ferr_count", {24'd0, frame_err_count}, 32'd1);
`endif
    expect_good(8'h3C);
    send_frame(8'h3C);
    send_bit(1'b1, 4);
    check_idle_outputs("after_ferr", 8'h3C, 17'd3, 8'd1);

    // Reset in the middle of data bit 4 of 0x99.
    send_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) send_bit(((8'h99 >> i) & 8'h01) != 0, CPB);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_ferr", {31'd0, frame_error}, 32'd0);
    check_idle_outputs("midrst", 8'h00, 17'd0, 8'd0);
    rst = 1'b0;
    m_bytes = '0; m_lines = '0; m_data = '0;
    send_bit(1'b1, 3 * CPB);
    expect_good(8'hA5);
    send_frame(8'hA5);
    send_bit(1'b1, 4);
    check_idle_outputs("after_rst", 8'hA5, 17'd1, 8'd0);

    // Preload byte_counter to 5.
    for (int k = 0; k < 4; k++) begin
      expect_good(8'h30 + 8'(k));
      send_frame(8'h30 + 8'(k));
    end
    send_bit(1'b1, 4);
    check_idle_outputs("preload", 8'h33, 17'd5, 8'd0);

    // clear_counters lands on the stop-sample edge. That edge is the 155th
    // posedge after the start bit begins: 2 synchronizer clocks, 1 to leave
    // IDLE, then CPB/2 + 9*CPB. It is also the edge that raises rx_valid.
    begin
      exp_t e;
      e.is_err = 1'b0; e.data = 8'h77; e.bc = 17'd0; e.lc = 8'd0;
      exp_q.push_back(e);
      m_bytes = '0; m_lines = '0; m_data = 8'h77;
    end
    fork
      send_frame(8'h77);
      begin
        repeat (154) @(negedge clk);
        clear_counters = 1'b1;
        @(negedge clk);
        clear_counters = 1'b0;
      end
    join
    send_bit(1'b1, 4);
    check_idle_outputs("clear_vs_inc", 8'h77, 17'd0, 8'd0);

    // Drain: every expected event must have been seen.
    for (int t = 0; t < 4 * CPB && exp_q.size() != 0; t++) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("event_total", events, 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
